// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B decoder producing one-cycle step pulses,
// a held direction level, an N-bit wrap-around position and error flags.
// Optional input glitch filter enabled by defining QUAD_FILTER_EN.
module quad_step_decoder #(
    parameter int N           = 3,
    parameter int FILT_CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_a,
    input  logic         i_b,
    input  logic         i_clr,
    output logic         o_en,
    output logic         o_up_down,
    output logic [N-1:0] o_pos,
    output logic         o_err,
    output logic         o_err_sticky
);

    if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_bad_filt
        $error("FILT_CYCLES must be in 2..15");
    end

    logic [1:0]   sync1_q, sync2_q;
    logic [1:0]   vld_q;          // tracks when sync2_q holds a real sample
    logic         init_q, init_d;
    logic [1:0]   prev_q, prev_d;
    logic [1:0]   s;              // accepted A/B state this cycle
    logic         en_q, en_d;
    logic         up_q, up_d;
    logic [N-1:0] pos_q, pos_d;
    logic         err_q, err_d;
    logic         sticky_q, sticky_d;
    logic         active;
    logic [1:0]   diff;
    logic         dir_up;

    // Two-flop synchronizer for both phases plus a fill tracker.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            vld_q   <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value and the pipeline really delays.
            sync1_q <= {i_a, i_b};
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

`ifdef QUAD_FILTER_EN
    logic [1:0]      lvl_q, lvl_d;
    logic [1:0][3:0] cnt_q, cnt_d;

    // Per-phase stability filter; the first valid sample seeds the level.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        lvl_d = lvl_q;
        cnt_d = '0;
        if (init_q) begin
            lvl_d = sync2_q;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (cnt_q[i] == 4'(FILT_CYCLES - 1)) begin
                        lvl_d[i] = sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Filter level and run-length registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign s = lvl_d;
`else
    assign s = sync2_q;
`endif

    // Step/error decode and next-state computation.
    always_comb begin
        active   = vld_q[1] && !init_q;
        diff     = s ^ prev_q;
        // Forward Gray order 00,01,11,10: the new B bit differs from the old A bit.
        dir_up   = prev_q[1] ^ s[0];
        init_d   = init_q && !vld_q[1];
        prev_d   = vld_q[1] ? s : prev_q;
        en_d     = active && (diff == 2'b01 || diff == 2'b10);
        err_d    = active && (diff == 2'b11);
        up_d     = en_d ? dir_up : up_q;
        pos_d    = pos_q;
        if (en_d) begin
            pos_d = dir_up ? pos_q + N'(1) : pos_q - N'(1);
        end
        sticky_d = sticky_q || err_d;
        if (i_clr) begin
            pos_d    = '0;
            sticky_d = 1'b0;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_q   <= 1'b1;
            prev_q   <= 2'b00;
            en_q     <= 1'b0;
            up_q     <= 1'b1;
            pos_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            init_q   <= init_d;
            prev_q   <= prev_d;
            en_q     <= en_d;
            up_q     <= up_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_en         = en_q;
    assign o_up_down    = up_q;
    assign o_pos        = pos_q;
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed A/B vectors, a Gray-index model
// checked every cycle, and literal expectations on latency and position.
module tb_quad_step_decoder;

    localparam int N    = 3;
    localparam int FILT = 4;
`ifdef QUAD_FILTER_EN
    localparam int LAT  = 3 + FILT - 1;
`else
    localparam int LAT  = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n, a, b, clr;
    logic         en, up_down, err, err_sticky;
    logic [N-1:0] pos;

    int n_tests = 0;
    int n_fail  = 0;

    quad_step_decoder #(.N(N), .FILT_CYCLES(FILT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_clr(clr),
        .o_en(en), .o_up_down(up_down), .o_pos(pos),
        .o_err(err), .o_err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] hist[$];
    logic       m_init, m_en, m_up, m_err, m_sticky;
    int         m_pos, m_run;
    logic [1:0] m_prev, m_lvl;

    function automatic int gray_idx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_init = 1'b1; m_en = 1'b0; m_up = 1'b1; m_err = 1'b0;
            m_sticky = 1'b0; m_pos = 0; m_run = 0; m_prev = 2'b00; m_lvl = 2'b00;
        end else begin
            logic [1:0] smp;
            int         d;
            m_en  = 1'b0;
            m_err = 1'b0;
            hist.push_back({a, b});
            if (hist.size() > 2) begin
                smp = hist.pop_front();
                if (m_init) begin
                    m_lvl  = smp;
                    m_prev = smp;
                    m_init = 1'b0;
                end else begin
`ifdef QUAD_FILTER_EN
                    if (smp != m_lvl) begin
                        m_run++;
                        if (m_run >= FILT) begin m_lvl = smp; m_run = 0; end
                    end else m_run = 0;
`else
                    m_lvl = smp;
`endif
                    d = (gray_idx(m_lvl) - gray_idx(m_prev) + 4) % 4;
                    if (d == 1) begin
                        m_en = 1'b1; m_up = 1'b1; m_pos = (m_pos + 1) % (1 << N);
                    end else if (d == 3) begin
                        m_en = 1'b1; m_up = 1'b0; m_pos = (m_pos + (1 << N) - 1) % (1 << N);
                    end else if (d == 2) begin
                        m_err = 1'b1; m_sticky = 1'b1;
                    end
                    m_prev = m_lvl;
                end
            end
            if (clr) begin
                m_pos = 0;
                m_sticky = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("en",         32'(en),         32'(m_en));
            check("up_down",    32'(up_down),    32'(m_up));
            check("pos",        32'(pos),        32'(m_pos));
            check("err",        32'(err),        32'(m_err));
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        end
    end

    // ---------------- directed stimulus ----------------
    // Drive a new A/B state and pin the output pulse to exactly LAT cycles later.
    task automatic step(input logic [1:0] ab, input logic exp_up, input logic exp_err, input string name);
        @(negedge clk);
        {a, b} = ab;
        repeat (LAT - 1) @(negedge clk);
        #2;
        check({name, "_early_en"}, 32'(en), 32'(0));
        @(negedge clk);
        #2;
        check({name, "_en"},  32'(en),  32'(!exp_err));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        if (!exp_err) check({name, "_dir"}, 32'(up_down), 32'(exp_up));
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; {a, b} = 2'b11; clr = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_up",  32'(up_down), 32'(1));
        check("rst_pos", 32'(pos),     32'(0));
        check("rst_en",  32'(en),      32'(0));
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        check("idle11_pos",    32'(pos),        32'(0));
        check("idle11_sticky", 32'(err_sticky), 32'(0));

        // Re-arm mid-operation with the lines at 00.
        @(negedge clk); rst_n = 1'b0; {a, b} = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Forward sequence: five up steps.
        step(2'b01, 1'b1, 1'b0, "up1");
        step(2'b11, 1'b1, 1'b0, "up2");
        step(2'b10, 1'b1, 1'b0, "up3");
        step(2'b00, 1'b1, 1'b0, "up4");
        step(2'b01, 1'b1, 1'b0, "up5");
        check("pos_after_up5", 32'(pos), 32'(5));

        clr_pulse(); #2;
        check("clr_pos", 32'(pos), 32'(0));
        step(2'b11, 1'b1, 1'b0, "up_to1");
        check("pos1", 32'(pos), 32'(1));

        // Reverse steps with wrap below zero.
        step(2'b01, 1'b0, 1'b0, "dn1"); check("pos_dn1", 32'(pos), 32'(0));
        step(2'b00, 1'b0, 1'b0, "dn2"); check("pos_dn2", 32'(pos), 32'(7));
        step(2'b10, 1'b0, 1'b0, "dn3"); check("pos_dn3", 32'(pos), 32'(6));

        // Double transition error.
        step(2'b00, 1'b1, 1'b0, "up_to7");
        step(2'b11, 1'b1, 1'b1, "dbl");
        check("err_pos",    32'(pos),        32'(7));
        check("err_sticky", 32'(err_sticky), 32'(1));
        check("err_dir",    32'(up_down),    32'(1));
        clr_pulse(); #2;
        check("clr2_pos",    32'(pos),        32'(0));
        check("clr2_sticky", 32'(err_sticky), 32'(0));

        // Clear in the same cycle as an up-step decode.
        @(negedge clk); {a, b} = 2'b10;
        repeat (LAT - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        #2;
        check("clrstep_en",  32'(en),      32'(1));
        check("clrstep_dir", 32'(up_down), 32'(1));
        check("clrstep_pos", 32'(pos),     32'(0));
        @(negedge clk);

        // Down wrap from 0, then up wrap from 7.
        step(2'b11, 1'b0, 1'b0, "wrap_dn"); check("wrap_dn_pos", 32'(pos), 32'(7));
        step(2'b10, 1'b1, 1'b0, "wrap_up"); check("wrap_up_pos", 32'(pos), 32'(0));

`ifdef QUAD_FILTER_EN
        // Two-cycle glitch on A is discarded; a held edge then steps.
        @(negedge clk); a = 1'b0;
        repeat (2) @(negedge clk);
        a = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        check("glitch_pos",    32'(pos),        32'(0));
        check("glitch_sticky", 32'(err_sticky), 32'(0));
        step(2'b00, 1'b1, 1'b0, "filt_up");
        check("filt_pos", 32'(pos), 32'(1));
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
